div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Sequencing and arbitration controller that shares one combinational 16/8 triangular array divider core (exact or any approximate variant) between NREQ requesters. It grants requests round-robin, registers operands, and holds them stable for MC_CYCLES multicycle settle cycles. It screens divide-by-zero and quotient overflow, captures q/r, and returns a tagged response through a valid/ready handshake. The divider core sits outside this block and connects through the div_* ports, so approximate variants can be swapped without touching the controller.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must equal clog2(NREQ)
MC_CYCLES, 2, cycles the core inputs are held before q/r are sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, at most one bit high
req_n  in  NREQ*16  dividends, requester i at [16i+15:16i]
req_d  in  NREQ*8  divisors, requester i at [8i+7:8i]
div_n  out  16  operand to the divider core
div_d  out  8  operand to the divider core
div_q  in  8  quotient from the divider core
div_r  in  8  remainder from the divider core
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  id of the requester being answered
rsp_q  out  8  quotient
rsp_r  out  8  remainder
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 overflow (n[15:8] >= d)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE, rr_ptr=0, mc_cnt=0, operand regs=0, rsp_valid=0, rsp_id/q/r/err=0, busy=0. req_ready is forced to 0 while rst=1. An in-flight transaction is dropped and no response is produced.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[grant]=1, combinational from req_valid and rr_ptr.
  - On accept (valid&ready), latch n/d/id and set rr_ptr=grant+1 (wrapping NREQ-1 to 0).
- Screening at accept uses the latched inputs:
  - d==0: go to RESP with q=8'hFF, r=n[7:0], err=01.
  - Otherwise, if n[15:8] >= d: go to RESP with q=8'hFF, r=8'hFF, err=10.
  - Otherwise go to CALC with mc_cnt=MC_CYCLES-1.
- CALC:
  - div_n/div_d are driven from the operand registers and stay constant for the whole state.
  - Each cycle mc_cnt decrements. When mc_cnt==0, capture div_q/div_r into rsp_q/rsp_r, set err=00, and move to RESP.
- RESP:
  - rsp_valid=1. rsp_id/q/r/err are registered and stay stable until the handshake.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
  - No new accept happens in the same cycle as the response handshake.
- Latency from the accept edge T to rsp_valid:
  - Valid divide: high at T+MC_CYCLES+1.
  - Error path: high at T+1.
  - Minimum issue interval with rsp_ready tied high is MC_CYCLES+2 cycles (error path: 2).
- div_n/div_d hold their last operands outside CALC, so the core does not toggle while idle.
- Any req_valid seen while not in IDLE is ignored (req_ready=0). Requesters must hold valid and operands until accepted.
- Priority among several valid requests is strictly round-robin from rr_ptr. A requester that is continuously valid is served at least once every NREQ grants.
- The controller does not check approximation error. div_q/div_r pass through bit-exact.

Decomposition:
- Shared package div_ctrl_pkg:
  - state enum (IDLE/CALC/RESP)
  - error codes ERR_OK=2'b00, ERR_DIV0=2'b01, ERR_OVF=2'b10
  - saturation constant Q_SAT=8'hFF
- One sub-module, div_rr_arbiter: parameter NREQ; inputs req_valid, rr_ptr, en; one-hot grant plus a binary grant index. It is purely combinational.
- Top level: FSM, counter, operand/response registers, screening logic.

Test Plan:
- Single request, MC_CYCLES=2, exact core model: req 1 sends n=16'h03E8, d=8'h0A → accepted at T; rsp_valid at T+3 with id=1, q=8'h64, r=8'h00, err=00.
- Divide-by-zero: n=16'h0012, d=0 → rsp_valid at T+1 with q=8'hFF, r=8'h12, err=01; div_n/div_d unchanged from the previous transaction.
- Overflow: n=16'h0A00, d=8'h0A → q=8'hFF, r=8'hFF, err=10, no CALC state entered.
- Round-robin: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0; each requester is served exactly once per 4 grants.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid and rsp_* stay stable, req_ready=0 throughout, busy=1; release → IDLE next cycle.
- Reset in CALC: assert rst at T+1 → next cycle state=IDLE, rsp_valid=0, rr_ptr=0, no response for the dropped request; a fresh request after reset completes normally.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller.
//   state_t  : controller FSM states
//   ERR_*    : response error codes
//   Q_SAT    : saturated quotient/remainder value reported on errors
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  localparam logic [7:0] Q_SAT = 8'hFF;

endpackage

// File: rtl/div_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_valid : per-requester valid
//   rr_ptr    : highest-priority requester index
//   en        : arbitration enable; no grant when low
//   grant     : one-hot grant
//   grant_idx : binary index of the granted requester
//   grant_any : some requester is granted
module div_rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  int unsigned       idx;
  logic [ID_W-1:0]   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // walk from rr_ptr upward, wrapping at NREQ (not a power of two in general)
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (en && !grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one external combinational 16/8 divider core between NREQ requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake; req_n/req_d packed operands
//   div_n/div_d         : operands held stable to the divider core
//   div_q/div_r         : divider core results, sampled after MC_CYCLES
//   rsp_*               : tagged response with valid/ready handshake
//   busy                : controller not idle
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_n,
  input  logic [NREQ*8-1:0]  req_d,
  output logic [15:0]        div_n,
  output logic [7:0]         div_d,
  input  logic [7:0]         div_q,
  input  logic [7:0]         div_r,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_q,
  output logic [7:0]         rsp_r,
  output logic [1:0]         rsp_err,
  output logic               busy
);

  localparam int unsigned      CNT_W   = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  mc_cnt;
  logic [15:0]       op_n;
  logic [7:0]        op_d;

  logic              arb_en;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [15:0]       sel_n;
  logic [7:0]        sel_d;

  assign arb_en = (state == IDLE) && !rst;

  div_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign div_n     = op_n;
  assign div_d     = op_d;
  assign busy      = (state != IDLE);

  always_comb begin
    sel_n = '0;
    sel_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(grant_idx) == i) begin
        sel_n = req_n[i*16 +: 16];
        sel_d = req_d[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      mc_cnt    <= '0;
      op_n      <= '0;
      op_d      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            rsp_id <= grant_idx;
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            // operand regs load only on the CALC path so the core stays quiet on errors
            if (sel_d == '0) begin
              rsp_q     <= Q_SAT;
              rsp_r     <= sel_n[7:0];
              rsp_err   <= ERR_DIV0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (sel_n[15:8] >= sel_d) begin
              rsp_q     <= Q_SAT;
              rsp_r     <= Q_SAT;
              rsp_err   <= ERR_OVF;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              op_n   <= sel_n;
              op_d   <= sel_d;
              mc_cnt <= MC_LOAD;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (mc_cnt == '0) begin
            rsp_q     <= div_q;
            rsp_r     <= div_r;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;
  localparam int unsigned MC   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_n;
  logic [NREQ*8-1:0]  req_d;
  logic [15:0]        div_n;
  logic [7:0]         div_d;
  logic [7:0]         div_q;
  logic [7:0]         div_r;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_q;
  logic [7:0]         rsp_r;
  logic [1:0]         rsp_err;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference-model state
  int unsigned ptr;
  logic [15:0] exp_dn;
  logic [7:0]  exp_dd;
  logic [15:0] tn [NREQ];
  logic [7:0]  td [NREQ];

  always #5 clk = ~clk;

  div_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .MC_CYCLES(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_d     (req_d),
    .div_n     (div_n),
    .div_d     (div_d),
    .div_q     (div_q),
    .div_r     (div_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // exact divider core
  always_comb begin
    div_q = '1;
    div_r = '1;
    if (div_d != 0) begin
      div_q = 8'(div_n / div_d);
      div_r = 8'(div_n % div_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < NREQ; i++) begin
      req_n[i*16 +: 16] = tn[i];
      req_d[i*8 +: 8]   = td[i];
    end
  endtask

  // One full transaction: offer mask, expect round-robin grant, check response,
  // hold rsp_ready low for bp cycles, then complete the handshake.
  task automatic transact(input logic [NREQ-1:0] mask, input int unsigned bp);
    int unsigned  g;
    int unsigned  nn, dd, lat, exp_lat;
    logic [NREQ-1:0] oh;
    logic [7:0]   eq, er;
    logic [1:0]   ee;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      int unsigned c;
      c = (ptr + k) % NREQ;
      if (mask[c]) begin
        g = c;
        break;
      end
    end
    oh = '0;
    oh[g] = 1'b1;
    nn = tn[g];
    dd = td[g];
    if (dd == 0) begin
      eq = 8'hFF; er = tn[g][7:0]; ee = 2'b01; exp_lat = 0;
    end else if (nn / dd > 255) begin
      eq = 8'hFF; er = 8'hFF; ee = 2'b10; exp_lat = 0;
    end else begin
      eq = 8'(nn / dd); er = 8'(nn % dd); ee = 2'b00; exp_lat = MC;
      exp_dn = tn[g]; exp_dd = td[g];
    end

    rsp_ready = 1'b0;
    drive(mask);
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 0);
    tick();
    ptr = (g + 1) % NREQ;
    drive(mask & ~oh);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      chk("req_ready_busy", 32'(req_ready), 0);
      chk("div_n_calc", 32'(div_n), 32'(exp_dn));
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_id", 32'(rsp_id), g);
    chk("rsp_q", 32'(rsp_q), 32'(eq));
    chk("rsp_r", 32'(rsp_r), 32'(er));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("div_n_hold", 32'(div_n), 32'(exp_dn));
    chk("div_d_hold", 32'(div_d), 32'(exp_dd));
    for (int unsigned b = 0; b < bp; b++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_fields", {14'd0, rsp_id, rsp_q, rsp_r, rsp_err}, {14'd0, ID_W'(g), eq, er, ee});
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_n     = '0;
    req_d     = '0;
    rsp_ready = 1'b0;
    ptr       = 0;
    exp_dn    = '0;
    exp_dd    = '0;
    for (int i = 0; i < NREQ; i++) begin
      tn[i] = '0;
      td[i] = '0;
    end

    // reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_fields", {14'd0, rsp_id, rsp_q, rsp_r, rsp_err}, 0);
    chk("rst_div_ops", {8'd0, div_n, div_d}, 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // single divide from requester 1
    tn[1] = 16'h03E8; td[1] = 8'h0A;
    transact(4'b0010, 0);
    // divide-by-zero from requester 2
    tn[2] = 16'h0012; td[2] = 8'h00;
    transact(4'b0100, 0);
    // overflow from requester 3
    tn[3] = 16'h0A00; td[3] = 8'h0A;
    transact(4'b1000, 0);

    // round-robin with all requesters valid: order 0,1,2,3,0; backpressure on one
    for (int i = 0; i < NREQ; i++) begin
      tn[i] = 16'(100 * (i + 1) + 7);
      td[i] = 8'(i + 3);
    end
    transact(4'b1111, 0);
    transact(4'b1111, 5);
    transact(4'b1111, 0);
    transact(4'b1111, 0);
    transact(4'b1111, 0);

    // reset while in CALC drops the transaction
    tn[1] = 16'h03E8; td[1] = 8'h0A;
    drive(4'b0010);
    #1;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rstcalc_valid", 32'(rsp_valid), 0);
    chk("rstcalc_busy", 32'(busy), 0);
    chk("rstcalc_ops", {8'd0, div_n, div_d}, 0);
    rst = 1'b0;
    ptr = 0; exp_dn = '0; exp_dd = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rstcalc_no_rsp", 32'(rsp_valid), 0);
    end
    transact(4'b1111, 0);

    // randomized traffic against the arithmetic model
    for (int t = 0; t < 30; t++) begin
      logic [NREQ-1:0] m;
      for (int i = 0; i < NREQ; i++) begin
        td[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        tn[i] = 16'($urandom_range(0, 65535));
        if (td[i] != 0 && $urandom_range(0, 2) != 0)
          tn[i] = 16'(32'(tn[i]) % (32'(td[i]) * 256));
      end
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      transact(m, $urandom_range(0, 3));
    end

    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
